merge_4: RTL
============

Name: merge_4

Overview:
- 4-to-1 merge: the reverse of split_4. Collects 34-bit packets from four producer channels A..D onto one output channel L.
- Tags each output packet with a 2-bit source index on Ctrl, the same encoding split_4 consumes (00=A, 01=B, 10=C, 11=D).
- Round-robin arbitration, one-entry holding slot per input, registered output with valid/ready backpressure.
- Sits where neuron/PE result streams converge toward a shared router or memory port.

Parameters:
- DW, 34, data width of every channel.
- CW, 16, width of the merged-packet counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- A_data  input  DW  channel A payload.
- A_valid  input  1  channel A payload present.
- A_ready  output  1  channel A slot empty; transfer when A_valid&&A_ready at clk edge.
- B_data / B_valid / B_ready: as A, channel B.
- C_data / C_valid / C_ready: as A, channel C.
- D_data / D_valid / D_ready: as A, channel D.
- L_data  output  DW  merged payload (registered).
- L_valid  output  1  L_data/Ctrl_data hold a packet.
- L_ready  input  1  downstream accepts; transfer when L_valid&&L_ready at edge.
- Ctrl_data  output  2  source index of L_data (00=A, 01=B, 10=C, 11=D).
- Ctrl_valid  output  1  always equal to L_valid.
- merged_count  output  CW  packets delivered on L, wraps modulo 2^CW.

Behaviour:
- Reset (rst=0, async):
  - slot_full[3:0]=0, rr_ptr=0.
  - L_valid=0, Ctrl_valid=0, L_data=0, Ctrl_data=0, merged_count=0.
  - All X_ready=0 while rst=0; X_ready=1 from the first cycle after release.
- Reset mid-operation discards all slot contents and any pending output packet, with no partial delivery.
- Input side, per channel i:
  - X_ready = rst && !slot_full[i], combinational from state only, never from X_valid.
  - On X_valid&&X_ready at an edge: slot_data[i]<=X_data, slot_full[i]<=1.
  - No same-edge refill: a slot drained at an edge shows ready only after that edge. Each input therefore sustains at most 1 packet per 2 cycles; the aggregate can reach 1 per cycle.
- Output load condition: load = (!L_valid || L_ready) && |slot_full.
- Arbitration:
  - Grant = first full slot scanning rr_ptr, rr_ptr+1, ... mod 4.
  - On load: L_data<=slot_data[g], Ctrl_data<=g, L_valid<=1, slot_full[g]<=0, rr_ptr<=(g+1) mod 4.
- No-load cases:
  - If L_valid&&L_ready and no slot is full: L_valid<=0. L_data and Ctrl_data hold their last values.
  - If L_valid&&!L_ready: L_data, Ctrl_data and L_valid are held stable (no change while stalled).
- Latency: packet accepted at edge N appears on L at edge N+1 at the earliest, if the output is free and the channel wins arbitration.
- Fairness: with all four slots continuously full and L_ready=1, grants cycle strictly A,B,C,D,A,... Starting order after reset is A.
- Counter: merged_count increments on every edge where L_valid&&L_ready; it wraps from 2^CW-1 to 0.
- Simultaneous events at one edge are all legal and independent: input capture into empty slots, output transfer, and load from a different slot.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with all X_valid=1 -> all X_ready=0, L_valid=0, merged_count=0. After release, X_ready=1 and nothing is captured during reset.
- Single path: one-cycle pulse C_valid=1, C_data=34'h12345, L_ready=1 -> next cycle L_valid=1, L_data=34'h12345, Ctrl_data=2'b10. Then L_valid=0 and merged_count=1.
- Round-robin: load all four slots at one edge (A=1, B=2, C=3, D=4), L_ready=1 -> over 4 consecutive cycles Ctrl_data=0,1,2,3 with data 1,2,3,4. merged_count=4.
- Backpressure: L_ready=0 with A and B pending -> L_data/Ctrl_data stay frozen at A's packet, A_ready=1 after its drain and B_ready=0. On release, B follows on the next cycle.
- Pointer fairness: D delivered last, then A and D both pending -> A is granted before D.
- Round-trip with split_4: split_4 random stream into A..D, L driven with L_ready=1 -> every packet appears exactly once, and Ctrl_data equals the split control value used. Counter wrap is checked with CW=4: after 16 packets merged_count=0.

Source files
------------

// File: rtl/merge_4.sv
// ============================================================================
//  Module   : merge_4
//  Purpose  : 4-to-1 packet merge. Collects DW-bit packets from four producer
//             channels A..D into one-entry holding slots and forwards them,
//             round-robin, onto a single registered output channel L. Each
//             output packet is tagged on Ctrl with its source index
//             (00=A, 01=B, 10=C, 11=D).
//  Ports    : clk, rst (async, active-low)
//             X_data/X_valid/X_ready  : producer channels, X in {A,B,C,D}
//             L_data/L_valid/L_ready  : merged output channel
//             Ctrl_data/Ctrl_valid    : source index of L_data
//             merged_count            : packets delivered on L, mod 2^CW
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module merge_4 #(
    parameter int DW = 34,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [DW-1:0] A_data,
    input  logic          A_valid,
    output logic          A_ready,
    input  logic [DW-1:0] B_data,
    input  logic          B_valid,
    output logic          B_ready,
    input  logic [DW-1:0] C_data,
    input  logic          C_valid,
    output logic          C_ready,
    input  logic [DW-1:0] D_data,
    input  logic          D_valid,
    output logic          D_ready,

    output logic [DW-1:0] L_data,
    output logic          L_valid,
    input  logic          L_ready,
    output logic [1:0]    Ctrl_data,
    output logic          Ctrl_valid,
    output logic [CW-1:0] merged_count
);

    localparam int c_NCH = 4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_NCH-1:0] slot_full_q, slot_full_d;
    logic [DW-1:0]    slot_data_q [c_NCH];
    logic [DW-1:0]    slot_data_d [c_NCH];
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             l_valid_q, l_valid_d;
    logic [DW-1:0]    l_data_q, l_data_d;
    logic [1:0]       ctrl_data_q, ctrl_data_d;
    logic [CW-1:0]    merged_count_q, merged_count_d;

    // ------------------------------------------------------------------
    // Input channels packed into arrays so the per-channel logic is uniform
    // ------------------------------------------------------------------
    logic [DW-1:0]    w_in_data [c_NCH];
    logic [c_NCH-1:0] w_in_valid;
    logic [c_NCH-1:0] w_in_ready;

    assign w_in_data[0] = A_data;
    assign w_in_data[1] = B_data;
    assign w_in_data[2] = C_data;
    assign w_in_data[3] = D_data;
    assign w_in_valid   = {D_valid, C_valid, B_valid, A_valid};

    // Ready depends only on state (and reset), never on the valid input, so
    // a slot drained at an edge can only be refilled after that edge.
    generate
        for (genvar gi = 0; gi < c_NCH; gi++) begin : g_ready
            assign w_in_ready[gi] = rst && !slot_full_q[gi];
        end
    endgenerate

    assign A_ready = w_in_ready[0];
    assign B_ready = w_in_ready[1];
    assign C_ready = w_in_ready[2];
    assign D_ready = w_in_ready[3];

    // ------------------------------------------------------------------
    // Round-robin grant: first full slot scanning from rr_ptr upward, mod 4
    // ------------------------------------------------------------------
    logic       w_found;
    logic [1:0] w_grant;
    logic [1:0] w_scan_idx;
    logic       w_load;
    logic       w_xfer;

    always_comb begin
        w_found    = 1'b0;
        w_grant    = 2'd0;
        w_scan_idx = 2'd0;
        for (int k = 0; k < c_NCH; k++) begin
            w_scan_idx = rr_ptr_q + 2'(k);
            if (!w_found && slot_full_q[w_scan_idx]) begin
                w_found = 1'b1;
                w_grant = w_scan_idx;
            end
        end
    end

    assign w_xfer = l_valid_q && L_ready;
    assign w_load = (!l_valid_q || L_ready) && w_found;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        slot_full_d    = slot_full_q;
        slot_data_d    = slot_data_q;
        rr_ptr_d       = rr_ptr_q;
        l_valid_d      = l_valid_q;
        l_data_d       = l_data_q;
        ctrl_data_d    = ctrl_data_q;
        merged_count_d = merged_count_q;

        // Capture only happens into empty slots, and the granted slot is
        // always full, so capture and drain never target the same slot.
        for (int i = 0; i < c_NCH; i++) begin
            if (w_in_valid[i] && w_in_ready[i]) begin
                slot_full_d[i] = 1'b1;
                slot_data_d[i] = w_in_data[i];
            end
        end

        if (w_load) begin
            l_data_d             = slot_data_q[w_grant];
            ctrl_data_d          = w_grant;
            l_valid_d            = 1'b1;
            slot_full_d[w_grant] = 1'b0;
            rr_ptr_d             = w_grant + 2'd1;
        end else if (w_xfer) begin
            // Output drained with nothing to replace it; data/ctrl hold.
            l_valid_d = 1'b0;
        end

        if (w_xfer) begin
            merged_count_d = merged_count_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full_q    <= '0;
            rr_ptr_q       <= 2'd0;
            l_valid_q      <= 1'b0;
            l_data_q       <= '0;
            ctrl_data_q    <= 2'd0;
            merged_count_q <= '0;
            for (int i = 0; i < c_NCH; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            slot_full_q    <= slot_full_d;
            rr_ptr_q       <= rr_ptr_d;
            l_valid_q      <= l_valid_d;
            l_data_q       <= l_data_d;
            ctrl_data_q    <= ctrl_data_d;
            merged_count_q <= merged_count_d;
            for (int i = 0; i < c_NCH; i++) begin
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign L_data       = l_data_q;
    assign L_valid      = l_valid_q;
    assign Ctrl_data    = ctrl_data_q;
    assign Ctrl_valid   = l_valid_q;
    assign merged_count = merged_count_q;

endmodule

`default_nettype wire
